// File: rtl/mont_mul_cios.sv
// Word-serial Montgomery multiplier (CIOS schedule): result = a*b*R^-1 mod n, R = 2^(WORD*NW).
// One WORDxWORD multiply-accumulate per cycle, shared between the multiply and reduction passes.
module mont_mul_cios #(
    parameter int WIDTH = 4096,
    parameter int WORD  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    input  logic [WORD-1:0]  n0inv,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             valid
);

    localparam int NW = WIDTH / WORD;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;
    localparam int TW = $clog2(NW + 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MULA  = 3'd1,
        S_CALCM = 3'd2,
        S_REDN  = 3'd3,
        S_NEXT  = 3'd4,
        S_SUB   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t           state_r;
    state_t           state_s;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] n_r;
    logic [WIDTH-1:0] d_r;
    logic [WIDTH-1:0] result_r;
    logic [WORD-1:0]  n0inv_r;
    logic [WORD-1:0]  m_r;
    logic [WORD-1:0]  c_r;
    logic             borrow_r;
    logic             busy_r;
    logic             valid_r;
    logic [WORD-1:0]  t_r [NW+2];
    logic [CW-1:0]    i_r;
    logic [CW-1:0]    j_r;

    logic             accept_s;
    logic             fin_s;
    logic             last_j_s;
    logic             last_i_s;
    logic [WORD-1:0]  mac_x_s;
    logic [WORD-1:0]  mac_y_s;
    logic [TW-1:0]    tj_s;
    logic [WORD-1:0]  t_j_s;
    logic [WORD-1:0]  n_j_s;
    logic [2*WORD-1:0] mac_s;
    logic [WORD:0]    top_s;
    logic [WORD:0]    sub_s;
    logic [WORD-1:0]  m_s;
    logic             keep_d_s;
    logic [WIDTH-1:0] t_low_s;

    function automatic logic [WORD-1:0] word_of(input logic [WIDTH-1:0] v, input logic [CW-1:0] k);
        word_of = v[k*WORD +: WORD];
    endfunction

    assign result = result_r;
    assign busy   = busy_r;
    assign valid  = valid_r;

    assign last_j_s = (j_r == CW'(NW - 1));
    assign last_i_s = (i_r == CW'(NW - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:  state_s = go ? S_MULA : S_IDLE;
            S_MULA:  state_s = last_j_s ? S_CALCM : S_MULA;
            S_CALCM: state_s = S_REDN;
            S_REDN:  state_s = last_j_s ? S_NEXT : S_REDN;
            S_NEXT:  state_s = last_i_s ? S_SUB : S_MULA;
            S_SUB:   state_s = last_j_s ? S_DONE : S_SUB;
            S_DONE:  state_s = go ? S_MULA : S_DONE;
            default: state_s = S_IDLE;
        endcase
    end

    // Control decode and MAC operand selection
    always_comb begin
        accept_s = 1'b0;
        fin_s    = 1'b0;
        mac_x_s  = {WORD{1'b0}};
        mac_y_s  = {WORD{1'b0}};
        case (state_r)
            S_IDLE: begin
                accept_s = go;
            end
            S_DONE: begin
                accept_s = go;
                fin_s    = ~valid_r & ~go;
            end
            S_MULA: begin
                mac_x_s = word_of(a_r, j_r);
                mac_y_s = word_of(b_r, i_r);
            end
            S_REDN: begin
                mac_x_s = m_r;
                mac_y_s = word_of(n_r, j_r);
            end
            default: begin
                accept_s = 1'b0;
            end
        endcase
    end

    // Shared arithmetic: MAC, top-word carry add, serial subtractor, m computation
    always_comb begin
        tj_s     = TW'(j_r);
        t_j_s    = t_r[tj_s];
        n_j_s    = word_of(n_r, j_r);
        mac_s    = {{WORD{1'b0}}, mac_x_s} * {{WORD{1'b0}}, mac_y_s}
                 + {{WORD{1'b0}}, t_j_s} + {{WORD{1'b0}}, c_r};
        top_s    = {1'b0, t_r[NW]} + {1'b0, mac_s[2*WORD-1:WORD]};
        sub_s    = {1'b0, t_j_s} - {1'b0, n_j_s} - {{WORD{1'b0}}, borrow_r};
        m_s      = t_r[0] * n0inv_r;
        keep_d_s = (t_r[NW] == {{(WORD-1){1'b0}}, 1'b1}) | ~borrow_r;
        t_low_s  = {WIDTH{1'b0}};
        for (int k = 0; k < NW; k++) begin
            t_low_s[k*WORD +: WORD] = t_r[k];
        end
    end

    // Datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            n_r      <= {WIDTH{1'b0}};
            d_r      <= {WIDTH{1'b0}};
            result_r <= {WIDTH{1'b0}};
            n0inv_r  <= {WORD{1'b0}};
            m_r      <= {WORD{1'b0}};
            c_r      <= {WORD{1'b0}};
            borrow_r <= 1'b0;
            busy_r   <= 1'b0;
            valid_r  <= 1'b0;
            i_r      <= {CW{1'b0}};
            j_r      <= {CW{1'b0}};
            for (int k = 0; k < NW + 2; k++) begin
                t_r[k] <= {WORD{1'b0}};
            end
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (accept_s) begin
                        a_r      <= a;
                        b_r      <= b;
                        n_r      <= n;
                        n0inv_r  <= n0inv;
                        m_r      <= {WORD{1'b0}};
                        c_r      <= {WORD{1'b0}};
                        borrow_r <= 1'b0;
                        i_r      <= {CW{1'b0}};
                        j_r      <= {CW{1'b0}};
                        valid_r  <= 1'b0;
                        busy_r   <= 1'b1;
                        for (int k = 0; k < NW + 2; k++) begin
                            t_r[k] <= {WORD{1'b0}};
                        end
                    end else if (fin_s) begin
                        result_r <= keep_d_s ? d_r : t_low_s;
                        valid_r  <= 1'b1;
                        busy_r   <= 1'b0;
                    end
                end
                S_MULA: begin
                    t_r[tj_s] <= mac_s[WORD-1:0];
                    c_r       <= mac_s[2*WORD-1:WORD];
                    if (last_j_s) begin
                        t_r[NW]   <= top_s[WORD-1:0];
                        t_r[NW+1] <= {{(WORD-1){1'b0}}, top_s[WORD]};
                        j_r       <= {CW{1'b0}};
                    end else begin
                        j_r <= j_r + CW'(1);
                    end
                end
                S_CALCM: begin
                    m_r <= m_s;
                    c_r <= {WORD{1'b0}};
                    j_r <= {CW{1'b0}};
                end
                S_REDN: begin
                    c_r <= mac_s[2*WORD-1:WORD];
                    // Low word of j=0 is zero by choice of m; later words land one slot down.
                    if (j_r != {CW{1'b0}}) begin
                        t_r[tj_s - TW'(1)] <= mac_s[WORD-1:0];
                    end
                    if (last_j_s) begin
                        t_r[NW-1] <= top_s[WORD-1:0];
                        t_r[NW]   <= t_r[NW+1] + {{(WORD-1){1'b0}}, top_s[WORD]};
                        t_r[NW+1] <= {WORD{1'b0}};
                        j_r       <= {CW{1'b0}};
                    end else begin
                        j_r <= j_r + CW'(1);
                    end
                end
                S_NEXT: begin
                    j_r      <= {CW{1'b0}};
                    c_r      <= {WORD{1'b0}};
                    borrow_r <= 1'b0;
                    if (!last_i_s) begin
                        i_r <= i_r + CW'(1);
                    end
                end
                S_SUB: begin
                    d_r[j_r*WORD +: WORD] <= sub_s[WORD-1:0];
                    borrow_r              <= sub_s[WORD];
                    j_r                   <= last_j_s ? {CW{1'b0}} : j_r + CW'(1);
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mont_mul_cios.sv
// Directed bench for mont_mul_cios at WIDTH=256 with n = 2^256-189 (R mod n = 189).
// Expected values come from hand-derived constants and a bit-serial halving reference model.
module tb_mont_mul_cios;

    localparam int WIDTH = 256;
    localparam logic [WIDTH-1:0] NMOD = {WIDTH{1'b1}} - 256'd188;

    logic             clk = 1'b0;
    logic             rst;
    logic             go;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] n;
    logic [63:0]      n0inv;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             valid;

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [63:0]      ninv_c;

    mont_mul_cios #(.WIDTH(WIDTH), .WORD(64)) dut (
        .clk    (clk),
        .rst    (rst),
        .go     (go),
        .a      (a),
        .b      (b),
        .n      (n),
        .n0inv  (n0inv),
        .result (result),
        .busy   (busy),
        .valid  (valid)
    );

    always #5 clk = ~clk;

    // a*b*2^-256 mod n by repeated halving mod n
    function automatic logic [WIDTH-1:0] mont_ref(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [512:0] acc;
        acc = {257'b0, x} * {257'b0, y};
        for (int k = 0; k < WIDTH; k++) begin
            if (acc[0]) acc = acc + {257'b0, NMOD};
            acc = acc >> 1;
        end
        if (acc >= {257'b0, NMOD}) acc = acc - {257'b0, NMOD};
        return acc[WIDTH-1:0];
    endfunction

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        @(negedge clk);
        a = x; b = y; n = NMOD; n0inv = ninv_c; go = 1'b1;
        @(negedge clk);
        go = 1'b0; a = ~x; b = ~y; n = ~NMOD; n0inv = ~ninv_c;
    endtask

    // Counts edges after acceptance until valid; optionally fires an extra go at cycle go_at.
    task automatic wait_valid(input int go_at, output int cnt);
        cnt = 0;
        chk("busy_after_go", {255'b0, busy}, 256'd1);
        chk("valid_dropped", {255'b0, valid}, 256'd0);
        while (valid !== 1'b1 && cnt < 200) begin
            @(negedge clk);
            cnt++;
            if (go === 1'b1) go = 1'b0;
            if (cnt == go_at) begin
                a = 256'd7; b = 256'd9; n = NMOD; n0inv = ninv_c; go = 1'b1;
            end
        end
        go = 1'b0;
    endtask

    task automatic run_case(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                            input logic [WIDTH-1:0] exp);
        int cnt;
        start(x, y);
        wait_valid(0, cnt);
        chk({tag, "_latency"}, WIDTH'(cnt), 256'd45);
        chk({tag, "_result"}, result, exp);
    endtask

    initial begin
        int               cnt;
        logic [WIDTH-1:0] rx;
        logic [WIDTH-1:0] ry;

        rst = 1'b1; go = 1'b0; a = '0; b = '0; n = '0; n0inv = '0;
        ninv_c = 64'd189;
        repeat (6) ninv_c = ninv_c * (64'd2 - 64'd189 * ninv_c);

        // Reset held three cycles, then idle with no go
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_result", result, 256'd0);
        chk("rst_busy", {255'b0, busy}, 256'd0);
        chk("rst_valid", {255'b0, valid}, 256'd0);
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            chk("idle_result", result, 256'd0);
            chk("idle_busy", {255'b0, busy}, 256'd0);
            chk("idle_valid", {255'b0, valid}, 256'd0);
        end

        run_case("conv_out", 256'd189, 256'd1, 256'd1);
        run_case("mont_one", 256'd189, 256'd189, 256'd189);
        run_case("zero", 256'd0, NMOD - 256'd1, 256'd0);
        run_case("nm1_sq", NMOD - 256'd1, NMOD - 256'd1, mont_ref(NMOD - 256'd1, NMOD - 256'd1));
        chk("nm1_sq_lt_n", {255'b0, (result < NMOD)}, 256'd1);

        // go while busy is ignored
        start(256'd189, 256'd1);
        wait_valid(10, cnt);
        chk("busy_go_latency", WIDTH'(cnt), 256'd45);
        chk("busy_go_result", result, 256'd1);
        repeat (5) @(negedge clk);
        chk("busy_go_hold_valid", {255'b0, valid}, 256'd1);
        chk("busy_go_hold_busy", {255'b0, busy}, 256'd0);
        chk("busy_go_hold_result", result, 256'd1);

        // Reset in the middle of an operation
        start(256'd189, 256'd189);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", {255'b0, busy}, 256'd0);
        chk("midrst_valid", {255'b0, valid}, 256'd0);
        chk("midrst_result", result, 256'd0);
        rst = 1'b0;
        run_case("after_rst", 256'd189, 256'd189, 256'd189);

        for (int t = 0; t < 200; t++) begin
            rx = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            ry = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (rx >= NMOD) rx = rx - NMOD;
            if (ry >= NMOD) ry = ry - NMOD;
            run_case("random", rx, ry, mont_ref(rx, ry));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
